// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue/retire controller: LEGv8 opcode patterns,
// ALU control codes and the controller state encoding.
package alu_issue_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Prefix forms: immediate/branch encodings spill into the low opcode bits.
  localparam logic [9:0] OP_ADDI_P = 10'b1001000100;
  localparam logic [9:0] OP_SUBI_P = 10'b1101000100;
  localparam logic [8:0] OP_MOVZ_P = 9'b110100101;
  localparam logic [7:0] OP_CBZ_P  = 8'b10110100;
  localparam logic [7:0] OP_CBNZ_P = 8'b10110101;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_ORR  = 4'b0100;
  localparam logic [3:0] ALU_EOR  = 4'b1001;
  localparam logic [3:0] ALU_MOV  = 4'b1101;
  localparam logic [3:0] ALU_CBZ  = 4'b0111;
  localparam logic [3:0] ALU_CBNZ = 4'b0001;
  localparam logic [3:0] ALU_NOP  = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode decode: exact 11-bit encodings are tested before the
// prefix encodings so a full match always wins.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [10:0] opcode_i,
  output logic [3:0]  alu_control_o,
  output logic        alu_src_o,
  output logic        is_branch_o,
  output logic        illegal_o
);

  always_comb begin
    alu_control_o = ALU_NOP;
    alu_src_o     = 1'b0;
    is_branch_o   = 1'b0;
    illegal_o     = 1'b0;
    if (opcode_i == OP_ADD) begin
      alu_control_o = ALU_ADD;
    end else if (opcode_i == OP_SUB) begin
      alu_control_o = ALU_SUB;
    end else if (opcode_i == OP_AND) begin
      alu_control_o = ALU_AND;
    end else if (opcode_i == OP_ORR) begin
      alu_control_o = ALU_ORR;
    end else if (opcode_i == OP_EOR) begin
      alu_control_o = ALU_EOR;
    end else if (opcode_i == OP_LDUR || opcode_i == OP_STUR) begin
      alu_control_o = ALU_ADD;
      alu_src_o     = 1'b1;
    end else if (opcode_i[10:1] == OP_ADDI_P) begin
      alu_control_o = ALU_ADD;
      alu_src_o     = 1'b1;
    end else if (opcode_i[10:1] == OP_SUBI_P) begin
      alu_control_o = ALU_SUB;
      alu_src_o     = 1'b1;
    end else if (opcode_i[10:2] == OP_MOVZ_P) begin
      alu_control_o = ALU_MOV;
      alu_src_o     = 1'b1;
    end else if (opcode_i[10:3] == OP_CBZ_P) begin
      alu_control_o = ALU_CBZ;
      is_branch_o   = 1'b1;
    end else if (opcode_i[10:3] == OP_CBNZ_P) begin
      alu_control_o = ALU_CBNZ;
      is_branch_o   = 1'b1;
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller around an external combinational ALU: accept one op,
// drive the ALU for a settle cycle, capture the result and hand it back.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        in_opcode,
  input  logic [DATA_W-1:0]  in_rdata1,
  input  logic [DATA_W-1:0]  in_sext,
  output logic [3:0]         alu_control,
  output logic               alu_src,
  output logic [DATA_W-1:0]  alu_rdata1,
  output logic [DATA_W-1:0]  alu_sext,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_branch_taken,
  output logic               out_is_branch,
  output logic               out_illegal,
  output logic [COUNT_W-1:0] op_count,
  output logic [COUNT_W-1:0] taken_count,
  output state_e             dbg_state
);

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [3:0]          alu_control_q, alu_control_d;
  logic                alu_src_q, alu_src_d;
  logic [DATA_W-1:0]   alu_rdata1_q, alu_rdata1_d;
  logic [DATA_W-1:0]   alu_sext_q, alu_sext_d;
  logic                is_branch_q, is_branch_d;
  logic                illegal_q, illegal_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_result_q, out_result_d;
  logic                out_taken_q, out_taken_d;
  logic                out_is_branch_q, out_is_branch_d;
  logic                out_illegal_q, out_illegal_d;
  logic [COUNT_W-1:0]  op_count_q, op_count_d;
  logic [COUNT_W-1:0]  taken_count_q, taken_count_d;

  logic [3:0] dec_control;
  logic       dec_src;
  logic       dec_branch;
  logic       dec_illegal;

  alu_issue_decode u_decode (
    .opcode_i      (in_opcode),
    .alu_control_o (dec_control),
    .alu_src_o     (dec_src),
    .is_branch_o   (dec_branch),
    .illegal_o     (dec_illegal)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a response holds until taken.
  always_comb begin
    state_d         = state_q;
    in_ready_d      = in_ready_q;
    alu_control_d   = alu_control_q;
    alu_src_d       = alu_src_q;
    alu_rdata1_d    = alu_rdata1_q;
    alu_sext_d      = alu_sext_q;
    is_branch_d     = is_branch_q;
    illegal_d       = illegal_q;
    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_taken_d     = out_taken_q;
    out_is_branch_d = out_is_branch_q;
    out_illegal_d   = out_illegal_q;
    op_count_d      = op_count_q;
    taken_count_d   = taken_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d       = ISSUE;
          in_ready_d    = 1'b0;
          alu_rdata1_d  = in_rdata1;
          alu_sext_d    = in_sext;
          alu_control_d = dec_control;
          alu_src_d     = dec_src;
          is_branch_d   = dec_branch;
          illegal_d     = dec_illegal;
        end
      end
      ISSUE: begin
        state_d         = RESP;
        out_valid_d     = 1'b1;
        out_result_d    = (is_branch_q || illegal_q) ? '0 : alu_result;
        out_taken_d     = alu_zero & is_branch_q;
        out_is_branch_d = is_branch_q;
        out_illegal_d   = illegal_q;
        alu_control_d   = ALU_NOP;
        alu_src_d       = 1'b0;
      end
      RESP: begin
        if (out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          if (!out_illegal_q) op_count_d = op_count_q + CNT_ONE;
          if (out_taken_q) taken_count_d = taken_count_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      in_ready_q      <= 1'b1;
      alu_control_q   <= ALU_NOP;
      alu_src_q       <= 1'b0;
      alu_rdata1_q    <= '0;
      alu_sext_q      <= '0;
      is_branch_q     <= 1'b0;
      illegal_q       <= 1'b0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_taken_q     <= 1'b0;
      out_is_branch_q <= 1'b0;
      out_illegal_q   <= 1'b0;
      op_count_q      <= '0;
      taken_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      in_ready_q      <= in_ready_d;
      alu_control_q   <= alu_control_d;
      alu_src_q       <= alu_src_d;
      alu_rdata1_q    <= alu_rdata1_d;
      alu_sext_q      <= alu_sext_d;
      is_branch_q     <= is_branch_d;
      illegal_q       <= illegal_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_taken_q     <= out_taken_d;
      out_is_branch_q <= out_is_branch_d;
      out_illegal_q   <= out_illegal_d;
      op_count_q      <= op_count_d;
      taken_count_q   <= taken_count_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign alu_control      = alu_control_q;
  assign alu_src          = alu_src_q;
  assign alu_rdata1       = alu_rdata1_q;
  assign alu_sext         = alu_sext_q;
  assign out_valid        = out_valid_q;
  assign out_result       = out_result_q;
  assign out_branch_taken = out_taken_q;
  assign out_is_branch    = out_is_branch_q;
  assign out_illegal      = out_illegal_q;
  assign op_count         = op_count_q;
  assign taken_count      = taken_count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a stand-in ALU (register operand reads back as
// rdata1); COUNT_W=4 so counter wrap is reachable quickly.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [10:0]   in_opcode = '0;
  logic [31:0]   in_rdata1 = '0;
  logic [31:0]   in_sext = '0;
  logic [3:0]    alu_control;
  logic          alu_src;
  logic [31:0]   alu_rdata1;
  logic [31:0]   alu_sext;
  logic [31:0]   alu_result;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic          out_branch_taken;
  logic          out_is_branch;
  logic          out_illegal;
  logic [CW-1:0] op_count;
  logic [CW-1:0] taken_count;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;
  int exp_tk = 0;

  alu_issue_ctrl #(.COUNT_W(CW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rdata1(in_rdata1), .in_sext(in_sext),
    .alu_control(alu_control), .alu_src(alu_src), .alu_rdata1(alu_rdata1),
    .alu_sext(alu_sext), .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_branch_taken(out_branch_taken), .out_is_branch(out_is_branch),
    .out_illegal(out_illegal), .op_count(op_count), .taken_count(taken_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: the CBNZ code reports zero when the operand is non-zero.
  logic [31:0] alu_b;
  always_comb begin
    alu_b = alu_src ? alu_sext : alu_rdata1;
    case (alu_control)
      4'b0010: alu_result = alu_rdata1 + alu_b;
      4'b1010: alu_result = alu_rdata1 - alu_b;
      4'b0110: alu_result = alu_rdata1 & alu_b;
      4'b0100: alu_result = alu_rdata1 | alu_b;
      4'b1001: alu_result = alu_rdata1 ^ alu_b;
      4'b1101: alu_result = alu_b;
      4'b0111: alu_result = alu_rdata1;
      4'b0001: alu_result = (alu_rdata1 == 32'd0) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [10:0] op;
    logic [31:0] a;
    logic [31:0] s;
    logic [3:0]  ctl;
    logic        src;
    logic [31:0] res;
    logic        br;
    logic        tk;
    logic        ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level meaning of each opcode, using the stand-in ALU's operands.
  function automatic vec_t ref_model(input logic [10:0] op, input logic [31:0] a,
                                     input logic [31:0] s);
    vec_t v;
    v = '{op: op, a: a, s: s, ctl: 4'b0000, src: 1'b0, res: 32'd0,
          br: 1'b0, tk: 1'b0, ill: 1'b0};
    if (op == 11'b10001011000) begin v.ctl = 4'b0010; v.res = a + a; end
    else if (op == 11'b11001011000) begin v.ctl = 4'b1010; v.res = 32'd0; end
    else if (op == 11'b10001010000) begin v.ctl = 4'b0110; v.res = a; end
    else if (op == 11'b10101010000) begin v.ctl = 4'b0100; v.res = a; end
    else if (op == 11'b11001010000) begin v.ctl = 4'b1001; v.res = 32'd0; end
    else if (op == 11'b11111000010 || op == 11'b11111000000 || op ==? 11'b1001000100?) begin
      v.ctl = 4'b0010; v.src = 1'b1; v.res = a + s;
    end
    else if (op ==? 11'b1101000100?) begin v.ctl = 4'b1010; v.src = 1'b1; v.res = a - s; end
    else if (op ==? 11'b110100101??) begin v.ctl = 4'b1101; v.src = 1'b1; v.res = s; end
    else if (op ==? 11'b10110100???) begin v.ctl = 4'b0111; v.br = 1'b1; v.tk = (a == 0); end
    else if (op ==? 11'b10110101???) begin v.ctl = 4'b0001; v.br = 1'b1; v.tk = (a != 0); end
    else v.ill = 1'b1;
    return v;
  endfunction

  task automatic do_op(input vec_t v, input int hold);
    logic [31:0] res_seen;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_opcode = v.op; in_rdata1 = v.a; in_sext = v.s;
    @(posedge clk); #1;
    in_valid = 1'b0; in_opcode = $urandom_range(0, 2047);
    in_rdata1 = $urandom; in_sext = $urandom;
    chk("issue_ctl", 32'(alu_control), 32'(v.ctl));
    chk("issue_src", 32'(alu_src), 32'(v.src));
    chk("issue_rdata1", alu_rdata1, v.a);
    chk("issue_sext", alu_sext, v.s);
    chk("issue_in_ready", 32'(in_ready), 32'd0);
    chk("issue_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("resp_valid_n2", 32'(out_valid), 32'd1);
    chk("resp_result", out_result, v.res);
    chk("resp_is_branch", 32'(out_is_branch), 32'(v.br));
    chk("resp_taken", 32'(out_branch_taken), 32'(v.tk));
    chk("resp_illegal", 32'(out_illegal), 32'(v.ill));
    chk("resp_ctl_nop", 32'(alu_control), 32'd0);
    res_seen = out_result;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_opcode = 11'b11010010100;
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, res_seen);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_no_accept", 32'(alu_control), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (!v.ill) exp_ops++;
    if (v.tk) exp_tk++;
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    chk("done_state", 32'(dbg_state), 32'(IDLE));
    chk("op_count", 32'(op_count), 32'(exp_ops % (1 << CW)));
    chk("taken_count", 32'(taken_count), 32'(exp_tk % (1 << CW)));
  endtask

  vec_t vecs[10];
  logic [10:0] reps[12];
  logic [10:0] masks[12];

  initial begin
    vec_t v;
    logic [10:0] op;
    logic [31:0] a;
    //           op               a      s      ctl      src   res     br    tk    ill
    vecs[0] = '{11'b10001011000, 32'd5, 32'd0, 4'b0010, 1'b0, 32'd10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{11'b10010001001, 32'd7, 32'd3, 4'b0010, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{11'b10110100101, 32'd0, 32'd9, 4'b0111, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0};
    vecs[3] = '{11'b10110101000, 32'd4, 32'd0, 4'b0001, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0};
    vecs[4] = '{11'b10110101111, 32'd0, 32'd0, 4'b0001, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{11'b00000000000, 32'd6, 32'd2, 4'b0000, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{11'b11010001000, 32'd9, 32'd4, 4'b1010, 1'b1, 32'd5,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{11'b11010010111, 32'd1, 32'hbeef, 4'b1101, 1'b1, 32'hbeef, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{11'b10101010000, 32'h0f0, 32'd0, 4'b0100, 1'b0, 32'h0f0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{11'b11111000000, 32'd100, 32'd8, 4'b0010, 1'b1, 32'd108, 1'b0, 1'b0, 1'b0};

    reps = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
             11'b11001010000, 11'b11111000010, 11'b11111000000, 11'b10010001000,
             11'b11010001000, 11'b11010010100, 11'b10110100000, 11'b10110101000};
    masks = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0,
              11'd1, 11'd1, 11'd3, 11'd7, 11'd7};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ctl", 32'(alu_control), 32'd0);
    chk("rst_rdata1", alu_rdata1, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;

    for (int i = 0; i < 10; i++) do_op(vecs[i], (i == 3) ? 5 : 0);

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 11);
      op = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                       : (reps[r] | (11'($urandom) & masks[r]));
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      v = ref_model(op, a, $urandom);
      do_op(v, $urandom_range(0, 2));
    end

    // Reset while a response is pending: nothing retires, counters clear.
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 11'b10001011000; in_rdata1 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ops = 0; exp_tk = 0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ops", 32'(op_count), 32'd0);
    chk("midrst_taken", 32'(taken_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", out_result, 32'd0);

    for (int i = 0; i < 16; i++) do_op(vecs[0], 0);
    chk("wrap_op_count", 32'(op_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue/retire controller that drives the datapath ALU (ALU_control, ALUSrc, Read_data1, Sign_extend) and reads back its ALU_Result and Zero.
- Accepts one decoded LEGv8 instruction at a time over a valid/ready handshake.
- Decodes the 11-bit opcode to a 4-bit ALU control code and source select, and holds operands stable for one settle cycle.
- Captures result and branch decision, then presents them on a valid/ready response port.
- Maintains wrap-around performance counters.

Parameters:
- COUNT_W, 16: width of op_count and taken_count.
- DATA_W, 32: operand/result width; fixed at 32 to match the ALU.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_opcode  in  11  instruction bits [31:21]
- in_rdata1  in  32  register operand
- in_sext  in  32  sign-extended immediate
- alu_control  out  4  to ALU ALU_control
- alu_src  out  1  to ALU ALUSrc
- alu_rdata1  out  32  to ALU Read_data1
- alu_sext  out  32  to ALU Sign_extend
- alu_result  in  32  from ALU ALU_Result
- alu_zero  in  1  from ALU Zero
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts response
- out_result  out  32  captured ALU result
- out_branch_taken  out  1  CBZ/CBNZ condition true
- out_is_branch  out  1  response is CBZ/CBNZ
- out_illegal  out  1  opcode not decoded
- op_count  out  COUNT_W  completed legal operations
- taken_count  out  COUNT_W  taken branches

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; in_ready 1; alu_control 4'b0000; alu_src 0; alu_rdata1 and alu_sext 0; out_valid 0; all out_* 0; both counters 0.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: in_ready=1. On in_valid: latch in_rdata1→alu_rdata1 and in_sext→alu_sext, load the decoded alu_control/alu_src, and go to ISSUE. in_ready=0 outside IDLE.
  - ISSUE: exactly one cycle; the ALU settles combinationally. At the end of the cycle, capture alu_result→out_result, branch/illegal flags, and out_branch_taken = alu_zero & is_branch. Set out_valid=1 and go to RESP. Return alu_control to 4'b0000 and alu_src to 0.
  - RESP: hold all out_* stable while out_valid && !out_ready. On out_ready: out_valid=0, go to IDLE.
- Latency: accept at cycle N → out_valid asserted at N+2. Maximum throughput is one op per 3 cycles; no accept during RESP.
- Decode (opcode → alu_control, alu_src):
  - ADD 10001011000 → 0010, 0
  - SUB 11001011000 → 1010, 0
  - AND 10001010000 → 0110, 0
  - ORR 10101010000 → 0100, 0
  - EOR 11001010000 → 1001, 0
  - LDUR 11111000010 and STUR 11111000000 → 0010, 1
  - ADDI [10:1]=1001000100 → 0010, 1
  - SUBI [10:1]=1101000100 → 1010, 1
  - MOVZ [10:2]=110100101 → 1101, 1
  - CBZ [10:3]=10110100 → 0111, 0
  - CBNZ [10:3]=10110101 → 0001, 0
  - Exact 11-bit matches take priority over prefix matches.
- Illegal opcode:
  - alu_control=0000 and alu_src=0 in ISSUE; the response still completes.
  - out_illegal=1, out_result=0, out_branch_taken=0.
  - No counter update.
- For branches, out_result is forced to 0.
- Counters: op_count increments on response handshake of a legal op; taken_count increments on handshake when out_branch_taken=1. Both wrap from 2^COUNT_W-1 to 0 with no saturation.
- Reset mid-operation (ISSUE or RESP): abort the operation and apply the reset values in the next cycle. The aborted op is not counted.
- in_valid is ignored outside IDLE; no buffering.

Decomposition:
- alu_issue_pkg holds:
  - opcode constants (full and prefix forms)
  - ALU control code localparams (ALU_ADD=0010, ALU_SUB=1010, ALU_AND=0110, ALU_ORR=0100, ALU_EOR=1001, ALU_MOV=1101, ALU_CBZ=0111, ALU_CBNZ=0001, ALU_NOP=0000)
  - state enum {IDLE, ISSUE, RESP}
- One sub-module, alu_issue_decode: purely combinational, opcode → {alu_control, alu_src, is_branch, illegal}.

Test Plan:
- ADD with rdata1=5, sext=0, alu_result model=10 → alu_control=0010 and alu_src=0 during ISSUE; out_valid at N+2 with out_result=10; op_count=1.
- ADDI opcode 1001000100x, rdata1=7, sext=3 → alu_src=1, alu_control=0010, out_result=10.
- CBZ 10110100xxx with rdata1=0 (alu_zero=1) → out_is_branch=1, out_branch_taken=1, out_result=0, taken_count=1. Repeat with CBNZ and rdata1=4 → taken. CBNZ with rdata1=0 → not taken, taken_count unchanged.
- Backpressure: hold out_ready=0 for 5 cycles → out_* stable, in_ready=0, a new in_valid is not accepted. Release out_ready → IDLE on the next cycle.
- Opcode 00000000000 → out_illegal=1, alu_control=0000, op_count unchanged. Reset asserted during RESP → out_valid=0 and counters 0 on the next cycle.
- Counter wrap with COUNT_W=4: 16 legal ops → op_count returns to 0.
